// File: rtl/pipelined_rotator_pkg.sv
// Shared constants, types and elaboration-time helpers for the FFT twiddle rotator.
// Holds the twiddle table generator and the round/saturate helper.
package fft_pkg;

    localparam int DW_DEF    = 12;
    localparam int F_IN_DEF  = 9;
    localparam int F_W_DEF   = 10;
    localparam int F_OUT_DEF = 9;
    localparam int N_DEF     = 16;
    localparam int ROM_MAX   = 64;
    localparam int ROM_AW    = $clog2(ROM_MAX);
    localparam real PI       = 3.14159265358979323846;

    typedef struct packed {
        logic signed [DW_DEF-1:0] re;
        logic signed [DW_DEF-1:0] im;
    } cplx_t;

    typedef logic signed [ROM_MAX-1:0][1:0][31:0] rom_t;

    typedef struct packed {
        logic               sat;
        logic signed [31:0] val;
    } sat_res_t;

    // Taylor series keeps table generation free of tool-specific math builtins.
    function automatic real cos_t(input real x);
        real t = 1.0;
        real s = 1.0;
        for (int n = 1; n < 20; n++) begin
            t = -t * x * x / real'((2 * n - 1) * (2 * n));
            s = s + t;
        end
        return s;
    endfunction

    function automatic real sin_t(input real x);
        real t = x;
        real s = x;
        for (int n = 1; n < 20; n++) begin
            t = -t * x * x / real'((2 * n) * (2 * n + 1));
            s = s + t;
        end
        return s;
    endfunction

    function automatic int qround(input real x);
        if (x >= 0.0)
            return $rtoi(x + 0.5);
        else
            return -$rtoi(-x + 0.5);
    endfunction

    function automatic rom_t twiddle_rom(input int n, input int f_w);
        rom_t rom = '0;
        real  a;
        real  scale;
        scale = real'(1 << f_w);
        for (int k = 0; k < ROM_MAX; k++) begin
            if (k < n) begin
                a = 2.0 * PI * real'(k) / real'(n);
                if (a > PI)
                    a = a - 2.0 * PI;
                rom[k][0] = 32'(qround(cos_t(a) * scale));
                rom[k][1] = 32'(qround(-sin_t(a) * scale));
            end
        end
        return rom;
    endfunction

    function automatic sat_res_t sat_round(
        input logic signed [63:0] value,
        input int                 sh,
        input logic               mode,
        input int                 width
    );
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_res_t           r;
        v = value;
        if (mode)
            v = v + (64'sd1 <<< (sh - 1));
        v  = v >>> sh;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        r.sat = 1'b0;
        r.val = v[31:0];
        if (v > hi) begin
            r.sat = 1'b1;
            r.val = hi[31:0];
        end else if (v < lo) begin
            r.sat = 1'b1;
            r.val = lo[31:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/pipelined_rotator_if.sv
// Streaming sample bus for the rotator: valid/ready input and output channels.
// Master drives samples in and accepts results; slave is the rotator side.
interface pipelined_rotator_if #(
    parameter int DW = fft_pkg::DW_DEF,
    parameter int KW = $clog2(fft_pkg::N_DEF)
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] ip_r;
    logic signed [DW-1:0] ip_i;
    logic [KW-1:0]        k_idx;
    logic                 conj_w;
    logic                 round_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_r;
    logic signed [DW-1:0] out_i;

    modport master (
        output in_valid, ip_r, ip_i, k_idx, conj_w, round_mode, out_ready,
        input  in_ready, out_valid, out_r, out_i
    );

    modport slave (
        input  in_valid, ip_r, ip_i, k_idx, conj_w, round_mode, out_ready,
        output in_ready, out_valid, out_r, out_i
    );
endinterface

// File: rtl/pipelined_rotator_cmul_core.sv
// Two-stage complex multiplier: registered products, then combine/round/saturate.
// Stalls as a unit on en so it can sit inside any single-enable pipeline.
module cmul_core
    import fft_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int SH = F_IN_DEF + F_W_DEF - F_OUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 vi,
    input  logic signed [DW-1:0] a_r,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [DW-1:0] w_r,
    input  logic signed [DW-1:0] w_i,
    input  logic                 mode,
    output logic                 vo,
    output logic signed [DW-1:0] y_r,
    output logic signed [DW-1:0] y_i,
    output logic                 sat
);
    localparam int PW = 2 * DW + 1;

    logic                   v2;
    logic                   m2;
    logic signed [2*DW-1:0] p_rr;
    logic signed [2*DW-1:0] p_ii;
    logic signed [2*DW-1:0] p_ri;
    logic signed [2*DW-1:0] p_ir;
    logic signed [PW-1:0]   re;
    logic signed [PW-1:0]   im;
    sat_res_t               sr;
    sat_res_t               si;

    always_comb begin
        re = PW'(p_rr) - PW'(p_ii);
        im = PW'(p_ri) + PW'(p_ir);
        sr = sat_round(64'(re), SH, m2, DW);
        si = sat_round(64'(im), SH, m2, DW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            m2   <= 1'b0;
            p_rr <= '0;
            p_ii <= '0;
            p_ri <= '0;
            p_ir <= '0;
            vo   <= 1'b0;
            y_r  <= '0;
            y_i  <= '0;
            sat  <= 1'b0;
        end else if (en) begin
            v2   <= vi;
            m2   <= mode;
            p_rr <= a_r * w_r;
            p_ii <= a_i * w_i;
            p_ri <= a_r * w_i;
            p_ir <= a_i * w_r;
            vo   <= v2;
            y_r  <= sr.val[DW-1:0];
            y_i  <= si.val[DW-1:0];
            sat  <= sr.sat | si.sat;
        end
    end
endmodule

// File: rtl/pipelined_rotator.sv
// Streaming twiddle rotator: ROM lookup stage feeding a pipelined complex multiply.
// One global enable stalls all three stages when the output is blocked.
module pipelined_rotator
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DW_DEF,
    parameter int F_IN       = F_IN_DEF,
    parameter int F_W        = F_W_DEF,
    parameter int F_OUT      = F_OUT_DEF,
    parameter int N_POINTS   = N_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_rotator_if.slave   bus,
    input  logic                 sat_clr,
    output logic                 sat_flag
);
    localparam int   SH  = F_IN + F_W - F_OUT;
    localparam rom_t ROM = twiddle_rom(N_POINTS, F_W);

    logic                         en;
    logic                         v1;
    logic                         rm1;
    logic signed [DATA_WIDTH-1:0] ip_r1;
    logic signed [DATA_WIDTH-1:0] ip_i1;
    logic signed [DATA_WIDTH-1:0] w_r1;
    logic signed [DATA_WIDTH-1:0] w_i1;
    logic signed [DATA_WIDTH-1:0] rom_r;
    logic signed [DATA_WIDTH-1:0] rom_i;
    logic [ROM_AW-1:0]            idx;
    logic                         out_sat;

    assign en           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;
    assign idx          = ROM_AW'(bus.k_idx);
    assign rom_r        = ROM[idx][0][DATA_WIDTH-1:0];
    assign rom_i        = ROM[idx][1][DATA_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            rm1   <= 1'b0;
            ip_r1 <= '0;
            ip_i1 <= '0;
            w_r1  <= '0;
            w_i1  <= '0;
        end else if (en) begin
            v1    <= bus.in_valid;
            rm1   <= bus.round_mode;
            ip_r1 <= bus.ip_r;
            ip_i1 <= bus.ip_i;
            w_r1  <= rom_r;
            w_i1  <= bus.conj_w ? -rom_i : rom_i;
        end
    end

    cmul_core #(
        .DW (DATA_WIDTH),
        .SH (SH)
    ) u_cmul (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .vi    (v1),
        .a_r   (ip_r1),
        .a_i   (ip_i1),
        .w_r   (w_r1),
        .w_i   (w_i1),
        .mode  (rm1),
        .vo    (bus.out_valid),
        .y_r   (bus.out_r),
        .y_i   (bus.out_i),
        .sat   (out_sat)
    );

    // A saturating transfer wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_flag <= 1'b0;
        else if (bus.out_valid && bus.out_ready && out_sat)
            sat_flag <= 1'b1;
        else if (sat_clr)
            sat_flag <= 1'b0;
    end
endmodule
